// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the Sobel filter: two line buffers plus a
// shift window, issuing interior windows and holding each until done_i.
module sobel_window_gen #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic       clk_i_s,
  input  logic       rst_i_s,
  input  logic       pix_valid_i,
  input  logic [7:0] pix_i,
  output logic       pix_ready_o,
  output logic       en_o,
  output logic [7:0] data_o_0,
  output logic [7:0] data_o_1,
  output logic [7:0] data_o_2,
  output logic [7:0] data_o_3,
  output logic [7:0] data_o_4,
  output logic [7:0] data_o_5,
  output logic [7:0] data_o_6,
  output logic [7:0] data_o_7,
  output logic [7:0] data_o_8,
  input  logic       done_i,
  output logic       frame_done_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_FILL,
    S_PRESENT,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          pix_ready_q, pix_ready_d;
  logic          en_q, en_d;
  logic          frame_done_q, frame_done_d;
  logic          last_q, last_d;
  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];

  logic [7:0]    line0_mem [IMG_W];
  logic [7:0]    line1_mem [IMG_W];
  logic [7:0]    lb0_rd, lb1_rd;
  logic          accept, col_end, row_end, win_complete;

  assign accept       = pix_valid_i & pix_ready_q;
  assign lb0_rd       = line0_mem[col_q];
  assign lb1_rd       = line1_mem[col_q];
  assign col_end      = (col_q == COL_LAST);
  assign row_end      = (row_q == ROW_LAST);
  assign win_complete = (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    en_d         = en_q;
    frame_done_d = 1'b0;
    last_d       = last_q;
    win_d        = win_q;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          // Oldest column drops off the left; new column is {row r-2, row r-1, pixel}.
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
          win_d[2] = lb0_rd;
          win_d[3] = win_q[4];
          win_d[4] = win_q[5];
          win_d[5] = lb1_rd;
          win_d[6] = win_q[7];
          win_d[7] = win_q[8];
          win_d[8] = pix_i;
          if (col_end) begin
            col_d = '0;
            if (!row_end) row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (win_complete) begin
            state_d = S_PRESENT;
            en_d    = 1'b1;
            last_d  = col_end && row_end;
          end
        end
      end
      S_PRESENT: begin
        if (done_i) begin
          state_d      = S_GAP;
          en_d         = 1'b0;
          frame_done_d = last_q;
          if (last_q) begin
            col_d  = '0;
            row_d  = '0;
            last_d = 1'b0;
          end
        end
      end
      S_GAP:   state_d = S_FILL;
      default: state_d = S_FILL;
    endcase

    pix_ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk_i_s or posedge rst_i_s) begin
    if (rst_i_s) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      pix_ready_q  <= 1'b0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pix_ready_q  <= pix_ready_d;
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      win_q        <= win_d;
    end
  end

  // Line storage is never cleared; the row >= 2 rule keeps stale bytes out of issued windows.
  always_ff @(posedge clk_i_s) begin
    if (accept) begin
      line0_mem[col_q] <= lb1_rd;
      line1_mem[col_q] <= pix_i;
    end
  end

  assign pix_ready_o  = pix_ready_q;
  assign en_o         = en_q;
  assign frame_done_o = frame_done_q;
  assign data_o_0     = win_q[0];
  assign data_o_1     = win_q[1];
  assign data_o_2     = win_q[2];
  assign data_o_3     = win_q[3];
  assign data_o_4     = win_q[4];
  assign data_o_5     = win_q[5];
  assign data_o_6     = win_q[6];
  assign data_o_7     = win_q[7];
  assign data_o_8     = win_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame: reset, raster windows,
// frame boundary, handshake stress and reset while a window is presented.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix = 8'h00;
  logic       done = 1'b0;
  logic       pix_ready_o, en_o, frame_done_o;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0] dout [9];

  int checks = 0;
  int errors = 0;
  int en_rises = 0;
  int fd_cycles = 0;
  logic en_prev = 1'b0;

  logic [7:0] img [H][W];
  logic [7:0] exp_win [9];

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i_s      (clk),
    .rst_i_s      (rst),
    .pix_valid_i  (pix_valid),
    .pix_i        (pix),
    .pix_ready_o  (pix_ready_o),
    .en_o         (en_o),
    .data_o_0     (d0),
    .data_o_1     (d1),
    .data_o_2     (d2),
    .data_o_3     (d3),
    .data_o_4     (d4),
    .data_o_5     (d5),
    .data_o_6     (d6),
    .data_o_7     (d7),
    .data_o_8     (d8),
    .done_i       (done),
    .frame_done_o (frame_done_o)
  );

  assign dout[0] = d0;
  assign dout[1] = d1;
  assign dout[2] = d2;
  assign dout[3] = d3;
  assign dout[4] = d4;
  assign dout[5] = d5;
  assign dout[6] = d6;
  assign dout[7] = d7;
  assign dout[8] = d8;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_o && !en_prev) en_rises++;
    en_prev = en_o;
    if (frame_done_o) fd_cycles++;
  end

  // Presents one pixel and waits (bounded) for the edge that accepts it.
  task automatic send_pix(input logic [7:0] p);
    bit   acc;
    logic rdy;
    acc = 1'b0;
    pix_valid = 1'b1;
    pix = p;
    for (int n = 0; n < 200 && !acc; n++) begin
      rdy = pix_ready_o;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    pix_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout pixel %h got no_accept want accept", p);
    end
  endtask

  task automatic finish_window(input int dly, input bit last);
    repeat (dly) begin
      @(posedge clk);
      #1;
      checks++;
      if (en_o !== 1'b1) begin
        errors++;
        $display("FAIL hold_en got %b want 1", en_o);
      end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (dout[k] !== exp_win[k]) begin
          errors++;
          $display("FAIL hold_data%0d got %h want %h", k, dout[k], exp_win[k]);
        end
      end
    end
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    checks++;
    if (en_o !== 1'b0 || pix_ready_o !== 1'b0 || frame_done_o !== last) begin
      errors++;
      $display("FAIL gap got en=%b rdy=%b fd=%b want en=0 rdy=0 fd=%b",
               en_o, pix_ready_o, frame_done_o, last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (en_o !== 1'b0 || pix_ready_o !== 1'b1 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL refill got en=%b rdy=%b fd=%b want en=0 rdy=1 fd=0",
               en_o, pix_ready_o, frame_done_o);
    end
  endtask

  task automatic drive_frame(input int maxgap, input int mindly, input int maxdly, input bit inject);
    int r0, f0, gap;
    r0 = en_rises;
    f0 = fd_cycles;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) begin
          pix_valid = 1'b0;
          done = inject ? 1'($urandom_range(0, 1)) : 1'b0;
          @(posedge clk);
          #1;
          done = 1'b0;
        end
        send_pix(img[r][c]);
        if (r >= 2 && c >= 2) begin
          for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
              exp_win[3*dy+dx] = img[r-2+dy][c-2+dx];
          checks++;
          if (en_o !== 1'b1 || pix_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL win_start r%0d c%0d got en=%b rdy=%b want en=1 rdy=0",
                     r, c, en_o, pix_ready_o);
          end
          for (int k = 0; k < 9; k++) begin
            checks++;
            if (dout[k] !== exp_win[k]) begin
              errors++;
              $display("FAIL win r%0d c%0d data%0d got %h want %h", r, c, k, dout[k], exp_win[k]);
            end
          end
          finish_window(int'($urandom_range(mindly, maxdly)), (r == H-1) && (c == W-1));
        end else begin
          checks++;
          if (en_o !== 1'b0) begin
            errors++;
            $display("FAIL no_win r%0d c%0d got en=%b want 0", r, c, en_o);
          end
        end
      end
    end
    checks++;
    if (en_rises - r0 !== 4) begin
      errors++;
      $display("FAIL en_count got %0d want 4", en_rises - r0);
    end
    checks++;
    if (fd_cycles - f0 !== 1) begin
      errors++;
      $display("FAIL frame_done_cycles got %0d want 1", fd_cycles - f0);
    end
  endtask

  task automatic test_reset();
    pix_valid = 1'b1;
    done = 1'b1;
    pix = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (en_o !== 1'b0 || pix_ready_o !== 1'b0 || frame_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got en=%b rdy=%b fd=%b want 0 0 0", en_o, pix_ready_o, frame_done_o);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (dout[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_data%0d got %h want 00", k, dout[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    done = 1'b0;
    checks++;
    if (pix_ready_o !== 1'b1 || en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b en=%b want rdy=1 en=0", pix_ready_o, en_o);
    end
  endtask

  task automatic test_raster_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(16*r + c);
    drive_frame(0, 5, 5, 1'b0);
  endtask

  task automatic test_frame_boundary();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(8'h80 + 16*r + c);
    drive_frame(0, 2, 2, 1'b0);
  endtask

  task automatic test_stress();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = 8'($urandom_range(0, 255));
      drive_frame(3, 1, 40, 1'b1);
    end
  endtask

  task automatic test_reset_mid_present();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(8'h40 + 16*r + c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W && !(r == 2 && c > 2); c++)
        send_pix(img[r][c]);
    checks++;
    if (en_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_present_en got %b want 1", en_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (en_o !== 1'b0 || pix_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got en=%b rdy=%b want 0 0", en_o, pix_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b want 1", pix_ready_o);
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'(8'hC0 + 16*r + c);
    drive_frame(0, 1, 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_raster_frame();
    test_frame_boundary();
    test_stress();
    test_reset_mid_present();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
